shift_feeder: RTL and testbench
===============================

SHIFT_FEEDER -- requirements
Module: shift_feeder

Interface
REQ-001 The block SHALL have parameter NIB, default 4, meaning the number of 4-bit nibbles serialized per word; legal range 1..8.
REQ-002 The block SHALL have parameter FLUSH_LEN, default 4, meaning the number of zero-fill shift cycles after the data nibbles; legal range 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port load_valid, input, 1 bit: a parallel word is offered.
REQ-006 The block SHALL have port load_data, input, 4*NIB bits: the parallel word, with nibble 0 in bits [3:0].
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block accepts a word on this cycle.
REQ-008 The block SHALL have port abort, input, 1 bit: cancel the transfer in progress.
REQ-009 The block SHALL have port si, output, 4 bits: the nibble stream to the downstream shifter's si input.
REQ-010 The block SHALL have port shn, output, 1 bit: the shift enable to the downstream shifter's shn input.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking completion of a full transfer.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-013 The FSM SHALL have exactly four states: IDLE, SHIFT, FLUSH and DONE.
REQ-014 In IDLE, the outputs SHALL be load_ready=1, shn=0, si=0 and done=0.
REQ-015 A word SHALL be accepted at a clock edge where load_valid=1 and load_ready=1; load_data is captured into the internal word register and the state becomes SHIFT.
REQ-016 In SHIFT, the outputs SHALL be shn=1, load_ready=0 and si=nibble[cnt]; cnt starts at 0 and increments each cycle, giving LSN-first order.
REQ-017 SHIFT SHALL last exactly NIB cycles; the first data nibble appears on si in the cycle immediately after the accept edge.
REQ-018 After SHIFT, the state SHALL go to FLUSH if FLUSH_LEN>0, otherwise to DONE.
REQ-019 In FLUSH, the outputs SHALL be shn=1 and si=0 for exactly FLUSH_LEN cycles, after which the state goes to DONE.
REQ-020 In DONE, the outputs SHALL be done=1, shn=0, si=0 and load_ready=0 for exactly one cycle, after which the state returns to IDLE.
REQ-021 Per word, the sequence from the accept edge SHALL be: NIB cycles of data, FLUSH_LEN cycles of zero fill, 1 cycle of done, then load_ready=1 again; with defaults this is 10 cycles edge-to-edge from accept to the next possible accept.
REQ-022 load_valid and load_data SHALL be ignored outside IDLE; the captured word SHALL NOT change mid-transfer.
REQ-023 abort=1 sampled in SHIFT or FLUSH SHALL send the state to IDLE at that edge, with outputs shn=0, si=0 and done=0 from the next cycle; no done pulse is produced.
REQ-024 abort sampled in IDLE or DONE SHALL have no effect; in particular, a DONE pulse is not suppressed.
REQ-025 When abort and load_valid are both 1 in IDLE, the word SHALL be accepted, since abort is ignored in IDLE.
REQ-026 cnt SHALL be sized to hold max(NIB, FLUSH_LEN)-1 and SHALL be cleared on every state entry; it SHALL never wrap inside a state.

Reset
REQ-027 While rst=1 at a clock edge, the state SHALL become IDLE, cnt=0 and the word register=0, so outputs are load_ready=1, shn=0, si=0 and done=0 from the next cycle.
REQ-028 rst SHALL have priority over abort and load_valid.
REQ-029 rst asserted mid-SHIFT or mid-FLUSH SHALL end the transfer with no done pulse.
REQ-030 After rst deasserts, the block SHALL accept a word at the first edge where load_valid=1.

Verification
REQ-031 The bench SHALL cover basic transfer: rst for 1 cycle, then load_data=16'hC5A3 with load_valid for 1 cycle -> si=3,A,5,C on 4 consecutive cycles with shn=1, then 4 cycles of si=0 with shn=1, then done=1 for 1 cycle, then load_ready=1.
REQ-032 The bench SHALL cover back-to-back words: load_valid held high with load_data=16'h000A then 16'h1100 -> second accept occurs exactly 10 cycles after the first; second sequence is si=0,0,1,1 followed by the flush.
REQ-033 The bench SHALL cover abort: abort=1 on the 3rd SHIFT cycle of 16'hFFFF -> shn=0 and si=0 on the next cycle, done never asserts, load_ready=1.
REQ-034 The bench SHALL cover reset mid-operation: rst=1 during the 2nd FLUSH cycle -> shn=0 and done=0 on the next cycle, and a new word 16'h1234 is then serialized as 4,3,2,1.
REQ-035 The bench SHALL cover ignored input: load_data changed to 16'h0000 with load_valid=1 during SHIFT of 16'h9876 -> si still 6,7,8,9 and no second accept until load_ready=1.
REQ-036 The bench SHALL cover parameter edges: NIB=1 with FLUSH_LEN=0 and load_data=4'h7 -> si=7 with shn=1 for 1 cycle, then done=1 on the next cycle.

Source files
------------

// File: rtl/shift_feeder.sv
// shift_feeder: serializes a parallel word into a 4-bit nibble stream for a
// downstream shifter.
//
// Each accepted word is sent least-significant nibble first, followed by a
// run of zero-fill shift cycles and then a single-cycle done pulse.
//
// All outputs come straight from flops. There is no combinational path from
// any input to any output.
//
// Ports:
//   clk        - single clock; all state updates on its rising edge
//   rst        - synchronous, active-high reset
//   load_valid - a parallel word is offered
//   load_data  - parallel word; nibble 0 is in bits [3:0]
//   load_ready - the block accepts a word this cycle
//   abort      - cancel the transfer in progress (SHIFT/FLUSH only)
//   si         - nibble stream to the downstream shifter
//   shn        - shift enable to the downstream shifter
//   done       - one-cycle pulse after a complete transfer
//
// state | meaning
// IDLE  | waiting for a word; load_ready=1
// SHIFT | driving data nibbles LSN-first, NIB cycles
// FLUSH | driving zero fill with shn=1, FLUSH_LEN cycles
// DONE  | one-cycle done pulse, then back to IDLE
module shift_feeder #(
    parameter int NIB       = 4,
    parameter int FLUSH_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [4*NIB-1:0] load_data,
    output logic             load_ready,
    input  logic             abort,
    output logic [3:0]       si,
    output logic             shn,
    output logic             done
);

    localparam int MAX_LEN = (NIB > FLUSH_LEN) ? NIB : FLUSH_LEN;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] NIB_LAST   = CW'(NIB - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [4*NIB-1:0] word, word_n;
    logic             load_ready_n;
    logic             shn_n;
    logic             done_n;
    logic [3:0]       si_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            word       <= '0;
            load_ready <= 1'b1;
            shn        <= 1'b0;
            si         <= 4'h0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            word       <= word_n;
            load_ready <= load_ready_n;
            shn        <= shn_n;
            si         <= si_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        word_n  = word;

        case (state)
            IDLE: begin
                // abort is deliberately not looked at here
                if (load_valid) begin
                    word_n  = load_data;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == NIB_LAST) begin
                    state_n = (FLUSH_LEN > 0) ? FLUSH : DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == FLUSH_LAST) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // alongside it and still line up with the state they describe.
    always_comb begin
        load_ready_n = (state_n == IDLE);
        shn_n        = (state_n == SHIFT) || (state_n == FLUSH);
        done_n       = (state_n == DONE);
        si_n         = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if ((state_n == SHIFT) && (cnt_n == CW'(i))) begin
                si_n = word_n[4*i +: 4];
            end
        end
    end

endmodule

// File: tb/tb_shift_feeder.sv
// tb_shift_feeder: self-checking bench for shift_feeder.
//
// The main instance uses the default parameters, NIB=4 and FLUSH_LEN=4. It is
// checked every cycle against a schedule model. Each accepted word expands
// into a queue of per-cycle expected outputs.
//
// A second instance uses NIB=1 and FLUSH_LEN=0. It covers the smallest legal
// configuration with literal expectations.
module tb_shift_feeder;

    localparam int NIB = 4;
    localparam int FL  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data  = 16'h0;
    logic        abort      = 1'b0;
    logic        load_ready;
    logic [3:0]  si;
    logic        shn;
    logic        done;

    logic        load_valid2 = 1'b0;
    logic [3:0]  load_data2  = 4'h0;
    logic        abort2      = 1'b0;
    logic        load_ready2;
    logic [3:0]  si2;
    logic        shn2;
    logic        done2;

    shift_feeder #(.NIB(NIB), .FLUSH_LEN(FL)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .abort      (abort),
        .si         (si),
        .shn        (shn),
        .done       (done)
    );

    shift_feeder #(.NIB(1), .FLUSH_LEN(0)) dut_min (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid2),
        .load_data  (load_data2),
        .load_ready (load_ready2),
        .abort      (abort2),
        .si         (si2),
        .shn        (shn2),
        .done       (done2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- schedule model ----------------
    typedef struct packed {
        logic [3:0] si;
        logic       shn;
        logic       done;
        logic       ready;
        logic       busy;   // a transfer that abort may cancel
    } exp_t;

    localparam exp_t IDLE_O = '{si: 4'h0, shn: 1'b0, done: 1'b0, ready: 1'b1, busy: 1'b0};

    exp_t cur = IDLE_O;
    exp_t q[$];
    bit   model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            cur      = IDLE_O;
            model_on = 1'b1;
        end else if (cur.busy && abort) begin
            q.delete();
            cur = IDLE_O;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (cur.ready && load_valid) begin
            for (int i = 0; i < NIB; i++)
                q.push_back('{si: load_data[4*i +: 4], shn: 1'b1, done: 1'b0, ready: 1'b0, busy: 1'b1});
            for (int i = 0; i < FL; i++)
                q.push_back('{si: 4'h0, shn: 1'b1, done: 1'b0, ready: 1'b0, busy: 1'b1});
            q.push_back('{si: 4'h0, shn: 1'b0, done: 1'b1, ready: 1'b0, busy: 1'b0});
            cur = q.pop_front();
        end else begin
            cur = IDLE_O;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            n_checks++;
            if ({si, shn, done, load_ready} !== {cur.si, cur.shn, cur.done, cur.ready}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got si=%h shn=%b done=%b ready=%b expected si=%h shn=%b done=%b ready=%b",
                         $time, si, shn, done, load_ready, cur.si, cur.shn, cur.done, cur.ready);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] basic_exp [4] = '{4'h3, 4'hA, 4'h5, 4'hC};
    logic [3:0] b2b_exp   [4] = '{4'h0, 4'h0, 4'h1, 4'h1};
    logic [3:0] rst_exp   [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] ign_exp   [4] = '{4'h6, 4'h7, 4'h8, 4'h9};

    initial begin
        // reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("reset_ready", load_ready, 1);
        chk("reset_shn", shn, 0);
        chk("reset_si", si, 0);
        chk("reset_done", done, 0);
        chk("reset_ready_min", load_ready2, 1);

        // basic transfer
        load_valid = 1'b1;
        load_data  = 16'hC5A3;
        cyc();
        load_valid = 1'b0;
        chk("model_first_si", cur.si, 4'h3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("basic_si%0d", i), si, basic_exp[i]);
            chk($sformatf("basic_shn%0d", i), shn, 1);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("basic_flush_si%0d", i), si, 0);
            chk($sformatf("basic_flush_shn%0d", i), shn, 1);
            cyc();
        end
        chk("basic_done", done, 1);
        chk("basic_done_shn", shn, 0);
        chk("model_done", cur.done, 1);
        cyc();
        chk("basic_ready_again", load_ready, 1);
        chk("basic_done_cleared", done, 0);

        // back-to-back words
        load_valid = 1'b1;
        load_data  = 16'h000A;
        cyc();
        load_data = 16'h1100;
        chk("b2b_first_si", si, 4'hA);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("b2b_not_ready_k%0d", k), load_ready, 0);
        end
        cyc();
        chk("b2b_ready_k9", load_ready, 1);
        cyc();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_si%0d", i), si, b2b_exp[i]);
            chk($sformatf("b2b_shn%0d", i), shn, 1);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_flush_si%0d", i), si, 0);
            cyc();
        end
        chk("b2b_done", done, 1);
        cyc();

        // abort on the third SHIFT cycle
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        cyc();
        load_valid = 1'b0;
        cyc();
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_shn", shn, 0);
        chk("abort_si", si, 0);
        chk("abort_ready", load_ready, 1);
        chk("abort_done", done, 0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("abort_no_done%0d", k), done, 0);
        end

        // reset during the second FLUSH cycle
        load_valid = 1'b1;
        load_data  = 16'hBEEF;
        cyc();
        load_valid = 1'b0;
        repeat (4) cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_shn", shn, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", load_ready, 1);
        load_valid = 1'b1;
        load_data  = 16'h1234;
        cyc();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midrst_si%0d", i), si, rst_exp[i]);
            cyc();
        end
        repeat (5) cyc();

        // load inputs ignored mid-transfer
        load_valid = 1'b1;
        load_data  = 16'h9876;
        cyc();
        load_data = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ign_si%0d", i), si, ign_exp[i]);
            cyc();
        end
        for (int k = 4; k <= 8; k++) begin
            chk($sformatf("ign_not_ready_k%0d", k), load_ready, 0);
            cyc();
        end
        chk("ign_ready_k9", load_ready, 1);
        load_valid = 1'b0;
        cyc();
        chk("ign_no_accept_shn", shn, 0);
        chk("ign_no_accept_ready", load_ready, 1);

        // abort together with load_valid in IDLE still accepts
        abort      = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h4321;
        cyc();
        abort      = 1'b0;
        load_valid = 1'b0;
        chk("idle_abort_si", si, 4'h1);
        chk("idle_abort_shn", shn, 1);
        repeat (9) cyc();

        // NIB=1, FLUSH_LEN=0
        load_valid2 = 1'b1;
        load_data2  = 4'h7;
        cyc();
        load_valid2 = 1'b0;
        chk("min_si", si2, 4'h7);
        chk("min_shn", shn2, 1);
        chk("min_ready_low", load_ready2, 0);
        chk("min_no_done_yet", done2, 0);
        cyc();
        chk("min_done", done2, 1);
        chk("min_done_shn", shn2, 0);
        chk("min_done_si", si2, 0);
        cyc();
        chk("min_ready_again", load_ready2, 1);
        chk("min_done_cleared", done2, 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            abort      = ($urandom_range(0, 24) == 0);
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 16'($urandom);
            cyc();
        end
        rst        = 1'b0;
        abort      = 1'b0;
        load_valid = 1'b0;
        repeat (12) cyc();
        chk("final_idle_ready", load_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
